line_3_window_scanner: RTL
==========================

Name: line_3_window_scanner

Overview:
- Reader-side companion to the 3-row line buffer.
- Accepts one 3-row group (top, middle, bottom rows, each W pixels of K channels) per handshake.
- Sweeps a 3x3 window across the columns and emits one 3x3xK window per beat over a valid/ready stream to the downstream conv MAC array.
- Decouples row-rate delivery from window-rate consumption with full backpressure support.

Parameters:
- DATA_BITS, 8, bits per channel sample
- K, 6, channels per pixel
- W, 24, pixels per row
- COL_BITS, 5, width of column index; must satisfy 2^COL_BITS >= W

Ports:
- clk  input  1  clock; all logic on rising edge
- resetn  input  1  synchronous active-low reset, sampled on rising edge of clk
- row_1  input  W*K*DATA_BITS  top row; pixel x at bits [(x+1)*K*DATA_BITS-1 : x*K*DATA_BITS]
- row_2  input  W*K*DATA_BITS  middle row, same packing
- row_3  input  W*K*DATA_BITS  bottom row, same packing
- valid_i  input  1  row group valid
- ready_o  output  1  block can accept a row group this cycle
- window_o  output  9*K*DATA_BITS  window; element e=r*3+c (r=0..2 row_1..row_3, c=0..2 left..right) at bits [(e+1)*K*DATA_BITS-1 : e*K*DATA_BITS]
- col_o  output  COL_BITS  window column index of current beat
- last_o  output  1  current beat is final window of the row group
- valid_o  output  1  window valid
- ready_i  input  1  downstream accepts window

Behaviour:
- Reset (resetn=0 at edge):
  - state=IDLE, col=0, stored rows=0
  - valid_o=0, last_o=0, col_o=0, window_o=0, ready_o=1
  - Reset mid-scan aborts the group; no further beats are emitted.
- FSM states IDLE and SCAN.
  - IDLE: ready_o=1, valid_o=0. On valid_i=1: latch row_1..3, col=0, go to SCAN.
  - SCAN: valid_o=1. window_o, col_o and last_o are driven from latched rows and registered col only; there is no combinational path from inputs.
  - A beat completes when valid_o & ready_i.
  - Beat completes and col != LAST_COL: col=col+1.
  - Beat completes and col == LAST_COL: if valid_i=1, latch new rows, col=0, stay in SCAN with no bubble; otherwise go to IDLE.
- ready_o in SCAN = last_o & ready_i. This is the only combinational input-to-output path.
- valid_i while ready_o=0 is ignored; rows are not latched and no error is flagged. Upstream must hold its data.
- Backpressure: while valid_o=1 and ready_i=0, window_o, col_o and last_o hold stable.
- Latency: row group accepted at edge N -> first window valid in cycle after edge N.
- Throughput: one window per cycle when ready_i=1.
- Without padding: LAST_COL=W-3. Window at col j uses pixels x=j+c. last_o=(col==LAST_COL).
- col arithmetic is unsigned COL_BITS. col never exceeds LAST_COL, so it never wraps.
- Stored rows update only on acceptance. They are never modified mid-scan.

Optional Feature:
- Macro: LINE_3_WINDOW_SCANNER_ZERO_PAD_EN
- Defined:
  - LAST_COL=W-1; W windows per group.
  - Window at col j is centred: pixel x=j-1+c.
  - Pixels with x<0 or x>W-1 read as zero.
- Undefined:
  - W-2 windows per group, unpadded as above. No padding logic is synthesised.

Test Plan (W=4, K=1, DATA_BITS=8, COL_BITS=2; row_1=32'h13121110, row_2=32'h23222120, row_3=32'h33323130):
- No pad, ready_i=1, single group -> 2 beats:
  - col0 window_o=72'h323130222120121110, last_o=0
  - col1 window_o=72'h333231232221131211, last_o=1
  - valid_o rises one cycle after acceptance; IDLE after second beat.
- Backpressure: ready_i=0 for 3 cycles on col0 -> window_o, col_o=0 and last_o held; ready_o=0; col1 follows the cycle ready_i returns high.
- Back-to-back: during col1 beat with ready_i=1, present valid_i=1 with row_1=32'h47464544 -> ready_o=1, next cycle col0 of new group, no idle cycle.
- valid_i=1 during col0 beat -> ready_o=0, rows not relatched, col1 output unchanged.
- resetn=0 during col0 beat -> valid_o=0, ready_o=1, col_o=0 at next cycle; new group afterwards starts at col0.
- ZERO_PAD_EN defined -> 4 beats:
  - col0=72'h313000212000111000
  - col3=72'h003332002322001312, last_o=1 on col3

Source files
------------

// File: rtl/line_3_window_scanner.sv
// Sweeps a 3x3xK window across a latched 3-row group, one window per accepted beat.
// Optional zero padding (centred windows, W beats per group): define LINE_3_WINDOW_SCANNER_ZERO_PAD_EN.
module line_3_window_scanner #(
  parameter int DATA_BITS = 8,
  parameter int K         = 6,
  parameter int W         = 24,
  parameter int COL_BITS  = 5
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [W*K*DATA_BITS-1:0]   row_1,
  input  logic [W*K*DATA_BITS-1:0]   row_2,
  input  logic [W*K*DATA_BITS-1:0]   row_3,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [9*K*DATA_BITS-1:0]   window_o,
  output logic [COL_BITS-1:0]        col_o,
  output logic                       last_o,
  output logic                       valid_o,
  input  logic                       ready_i
);

  localparam int PIX = K * DATA_BITS;
  localparam int ROW = W * PIX;
`ifdef LINE_3_WINDOW_SCANNER_ZERO_PAD_EN
  localparam int LAST  = W - 1;
  localparam int X_OFF = 1;
`else
  localparam int LAST  = W - 3;
  localparam int X_OFF = 0;
`endif
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(LAST);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW-1:0]      rows_q [3];
  logic                load;
  logic                at_last;
  int                  x;

  assign at_last = (state_q == SCAN) && (col_q == LAST_COL);
  assign valid_o = (state_q == SCAN);
  assign last_o  = at_last;
  assign col_o   = col_q;
  // The only input-to-output path: a new group may enter as the final beat leaves.
  assign ready_o = (state_q == IDLE) || (at_last && ready_i);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    col_d   = col_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          load    = 1'b1;
          col_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (ready_i) begin
          if (!at_last) begin
            col_d = col_q + 1'b1;
          end else if (valid_i) begin
            load  = 1'b1;
            col_d = '0;
          end else begin
            col_d   = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      state_q <= IDLE;
      col_q   <= '0;
      // NOTE: the row store is a handful of wide registers, not a RAM, so clearing it on reset is cheap and keeps window_o defined.
      for (int r = 0; r < 3; r++) rows_q[r] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (load) begin
        rows_q[0] <= row_1;
        rows_q[1] <= row_2;
        rows_q[2] <= row_3;
      end
    end
  end

  // Window taps come only from the latched rows and registered column.
  always_comb begin
    window_o = '0;
    x        = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        x = int'(col_q) + c - X_OFF;
`ifdef LINE_3_WINDOW_SCANNER_ZERO_PAD_EN
        if (state_q == SCAN && x >= 0 && x < W)
          window_o[(r*3+c)*PIX +: PIX] = rows_q[r][x*PIX +: PIX];
`else
        if (state_q == SCAN)
          window_o[(r*3+c)*PIX +: PIX] = rows_q[r][x*PIX +: PIX];
`endif
      end
    end
  end

endmodule
